// File: rtl/lcd_write_engine.sv
// lcd_write_engine: FIFO-buffered HD44780 write-cycle generator (setup, EN pulse, execution wait).
// Define LCD_WORD_CNT_EN to add the saturating oWordCnt completed-word counter.
module lcd_write_engine #(
    parameter int SETUP_CYC     = 2,
    parameter int EN_HIGH_CYC   = 16,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int FIFO_AW       = 2
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [7:0]  iDATA,
    input  logic        iRS,
    input  logic        iStart,
    output logic        oReady,
    output logic        oDone,
    output logic        oBusy,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_RS
`ifdef LCD_WORD_CNT_EN
    ,
    output logic [15:0] oWordCnt
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [16:0] SETUP_LD = 17'(SETUP_CYC - 1);
    localparam logic [16:0] EN_LD    = 17'(EN_HIGH_CYC - 1);
    localparam logic [16:0] EXEC_LD  = 17'(EXEC_CYC - 1);
    localparam logic [16:0] LONG_LD  = 17'(LONG_EXEC_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, EXEC} state_t;

    state_t             state_q, state_d;
    logic [16:0]        cnt_q, cnt_d;
    logic [8:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               lcd_en_q, lcd_en_d, lcd_rs_q, lcd_rs_d, done_q, done_d;
    logic [7:0]         lcd_data_q, lcd_data_d;
    logic               push, pop, cnt_zero, long_cmd;

    assign oReady   = count_q != (FIFO_AW+1)'(DEPTH);
    assign push     = iStart && oReady;
    assign cnt_zero = cnt_q == '0;
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign long_cmd = !lcd_rs_q && lcd_data_q[7:2] == 6'd0 && lcd_data_q[1:0] != 2'd0;
    assign pop      = count_q != '0 && (state_q == IDLE || (state_q == EXEC && cnt_zero));

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        state_d    = state_q;
        cnt_d      = cnt_zero ? cnt_q : cnt_q - 1'b1;
        lcd_en_d   = lcd_en_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        done_d     = state_q == EXEC && cnt_zero;
        if (pop) begin
            state_d                = SETUP;
            cnt_d                  = SETUP_LD;
            {lcd_rs_d, lcd_data_d} = mem_q[rd_ptr_q];
        end else if (cnt_zero) begin
            case (state_q)
                SETUP: begin
                    state_d  = PULSE;
                    cnt_d    = EN_LD;
                    lcd_en_d = 1'b1;
                end
                PULSE: begin
                    state_d  = EXEC;
                    cnt_d    = long_cmd ? LONG_LD : EXEC_LD;
                    lcd_en_d = 1'b0;
                end
                EXEC:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lcd_en_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lcd_en_q   <= lcd_en_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            done_q     <= done_d;
            if (push) mem_q[wr_ptr_q] <= {iRS, iDATA};
        end
    end

    assign oDone    = done_q;
    assign oBusy    = state_q != IDLE || count_q != '0;
    assign LCD_EN   = lcd_en_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_DATA = lcd_data_q;
    assign LCD_RW   = 1'b0;

`ifdef LCD_WORD_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb word_cnt_d = (done_q && word_cnt_q != 16'hFFFF) ? word_cnt_q + 1'b1 : word_cnt_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) word_cnt_q <= '0;
        else         word_cnt_q <= word_cnt_d;
    end

    assign oWordCnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: randomized and directed bench for lcd_write_engine against a
// timing-formula reference model (word popped when engine free, done after S+E+W cycles).
module tb_lcd_write_engine;

    localparam int S = 2, E = 4, X = 10, L = 50, DEPTH = 4;

    logic        iCLK = 1'b0, iRST_N = 1'b0, iStart = 1'b0, iRS = 1'b0;
    logic [7:0]  iDATA = '0;
    logic        oReady, oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
    logic [7:0]  LCD_DATA;
`ifdef LCD_WORD_CNT_EN
    logic [15:0] oWordCnt;
`endif

    lcd_write_engine #(
        .SETUP_CYC(S), .EN_HIGH_CYC(E), .EXEC_CYC(X), .LONG_EXEC_CYC(L), .FIFO_AW(2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
        .oReady(oReady), .oDone(oDone), .oBusy(oBusy), .LCD_DATA(LCD_DATA),
        .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
`ifdef LCD_WORD_CNT_EN
        , .oWordCnt(oWordCnt)
`endif
    );

    always #5 iCLK = ~iCLK;

    int          n_tests = 0, n_fail = 0, cyc = 0, pop_e = 0, done_e = 0;
    logic [8:0]  mq[$];
    logic [8:0]  cur = '0;
    bit          active = 1'b0, m_done = 1'b0;
    logic [15:0] m_wcnt = '0;
    int          dq_e[$];
    logic [7:0]  dq_d[$];
    logic [7:0]  last_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int wait_of(input logic [8:0] w);
        return (!w[8] && w[7:0] inside {8'h01, 8'h02, 8'h03}) ? L : X;
    endfunction

    // Reference: a queued word starts on the first edge the engine is free and
    // finishes S+E+W edges later; occupancy below DEPTH means a push is accepted.
    task automatic model_step();
        bit acc;
        if (!iRST_N) begin
            mq.delete();
            cur    = '0;
            active = 1'b0;
            m_done = 1'b0;
            m_wcnt = '0;
        end else begin
            cyc++;
            acc = iStart && mq.size() < DEPTH;
            if (m_done && m_wcnt != 16'hFFFF) m_wcnt++;
            m_done = active && cyc == done_e;
            if (m_done) active = 1'b0;
            if (!active && mq.size() > 0) begin
                cur    = mq.pop_front();
                active = 1'b1;
                pop_e  = cyc;
                done_e = cyc + S + E + wait_of(cur);
            end
            if (acc) mq.push_back({iRS, iDATA});
        end
    endtask

    initial forever begin
        @(posedge iCLK or negedge iRST_N);
        model_step();
    end

    initial forever begin
        @(negedge iCLK);
        if (iRST_N) begin
            check("ready", 32'(oReady), 32'(mq.size() < DEPTH));
            check("done", 32'(oDone), 32'(m_done));
            check("busy", 32'(oBusy), 32'(active || mq.size() > 0));
            check("en", 32'(LCD_EN), 32'(active && cyc >= pop_e + S && cyc < pop_e + S + E));
            check("rs", 32'(LCD_RS), 32'(cur[8]));
            check("data", 32'(LCD_DATA), 32'(cur[7:0]));
            check("rw", 32'(LCD_RW), 32'(1'b0));
`ifdef LCD_WORD_CNT_EN
            check("wcnt", 32'(oWordCnt), 32'(m_wcnt));
`endif
            if (oDone) begin
                dq_e.push_back(cyc);
                dq_d.push_back(last_data);
            end
            last_data = LCD_DATA;
        end
    end

    task automatic push_word(input logic [8:0] w, output int acc_edge);
        bit will;
        acc_edge = -1;
        iStart = 1'b1;
        {iRS, iDATA} = w;
        for (int t = 0; t < 500; t++) begin
            will = mq.size() < DEPTH;
            @(posedge iCLK);
            #1;
            if (will) begin
                acc_edge = cyc;
                break;
            end
            @(negedge iCLK);
        end
        check("accepted", 32'(acc_edge >= 0), 32'(1'b1));
        @(negedge iCLK);
    endtask

    task automatic idle(input int n);
        iStart = 1'b0;
        repeat (n) @(negedge iCLK);
    endtask

    task automatic wait_dones(input int n);
        for (int t = 0; t < 6000 && dq_e.size() < n; t++) @(negedge iCLK);
        check("done_count", 32'(dq_e.size()), 32'(n));
    endtask

    logic [8:0] dir [5] = '{9'h141, 9'h001, 9'h101, 9'h003, 9'h038};
    int         lat [5] = '{17, 57, 17, 57, 17};

    initial begin
        int         a;
        int         acc [6];
        logic [8:0] w;
        repeat (3) @(negedge iCLK);
        check("rst_ready", 32'(oReady), 32'(1'b1));
        check("rst_done", 32'(oDone), 32'(1'b0));
        check("rst_busy", 32'(oBusy), 32'(1'b0));
        check("rst_en", 32'(LCD_EN), 32'(1'b0));
        check("rst_rs", 32'(LCD_RS), 32'(1'b0));
        check("rst_data", 32'(LCD_DATA), 32'(8'h00));
        check("rst_rw", 32'(LCD_RW), 32'(1'b0));
        iRST_N = 1'b1;
        idle(2);

        foreach (dir[i]) begin
            dq_e.delete();
            dq_d.delete();
            push_word(dir[i], a);
            iStart = 1'b0;
            wait_dones(1);
            if (dq_e.size() > 0) begin
                check("latency", 32'(dq_e[0] - a), 32'(lat[i]));
                check("word", 32'(dq_d[0]), 32'(dir[i][7:0]));
            end
            idle(3);
        end

        idle(100);
        check("hold_data", 32'(LCD_DATA), 32'(8'h38));
        check("hold_rs", 32'(LCD_RS), 32'(1'b0));
        check("hold_en", 32'(LCD_EN), 32'(1'b0));

        dq_e.delete();
        dq_d.delete();
        for (int i = 0; i < 6; i++) push_word(9'(9'h130 + i), acc[i]);
        iStart = 1'b0;
        check("bp_fill", 32'(acc[4] - acc[0]), 32'd4);
        check("bp_sixth", 32'(acc[5] - acc[0]), 32'd18);
        wait_dones(6);
        if (dq_e.size() > 0) check("bp_first", 32'(dq_e[0] - acc[0]), 32'd17);
        for (int i = 0; i < dq_e.size(); i++) check("bp_data", 32'(dq_d[i]), 32'(8'h30 + i));
        for (int i = 1; i < dq_e.size(); i++) check("bp_gap", 32'(dq_e[i] - dq_e[i-1]), 32'd16);
        idle(5);

        push_word(9'h155, a);
        iStart = 1'b0;
        repeat (4) @(negedge iCLK);
        check("pre_rst_en", 32'(LCD_EN), 32'(1'b1));
        #2 iRST_N = 1'b0;
        #1;
        check("arst_en", 32'(LCD_EN), 32'(1'b0));
        check("arst_done", 32'(oDone), 32'(1'b0));
        check("arst_ready", 32'(oReady), 32'(1'b1));
        check("arst_busy", 32'(oBusy), 32'(1'b0));
        repeat (3) @(negedge iCLK);
        dq_e.delete();
        dq_d.delete();
        iRST_N = 1'b1;
        idle(30);
        check("arst_no_done", 32'(dq_e.size()), 32'd0);
        push_word(9'h142, a);
        iStart = 1'b0;
        wait_dones(1);
        if (dq_e.size() > 0) check("arst_latency", 32'(dq_e[0] - a), 32'd17);
        idle(2);
`ifdef LCD_WORD_CNT_EN
        check("wcnt_after_rst", 32'(oWordCnt), 32'd1);
`endif

        dq_e.delete();
        dq_d.delete();
        for (int k = 0; k < 40; k++) begin
            w = {1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
            push_word(w, a);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 80));
        end
        iStart = 1'b0;
        wait_dones(40);
        idle(5);
        check("rnd_idle", 32'(oBusy), 32'(1'b0));

`ifdef LCD_WORD_CNT_EN
        #1 force dut.word_cnt_q = 16'hFFFE;
        m_wcnt = 16'hFFFE;
        #1 release dut.word_cnt_q;
        dq_e.delete();
        @(negedge iCLK);
        push_word(9'h141, a);
        push_word(9'h142, a);
        iStart = 1'b0;
        wait_dones(2);
        idle(2);
        check("wcnt_sat", 32'(oWordCnt), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish, %0d checks so far", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
